nes_controller_emulator: RTL and testbench

Device-side model of a standard NES controller (4021-style shift register). It responds to the latch and serial-clock lines driven by our NES reader, and serializes eight board button inputs onto the data line in active-low form. It lets the reader/counter/display chain be exercised on-board without a physical controller, with the reader looped back to this block. It also reports frame status for debug.

---
 rtl/nes_pkg.sv | 22 ++
 rtl/nes_sync_edge.sv | 32 +++
 rtl/nes_controller_emulator.sv | 129 ++++++++++++
 tb/tb_nes_controller_emulator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared NES controller definitions: frame width, button bit positions
// and the device-side state encoding. Used by the emulator, reader and benches.
package nes_pkg;

    localparam int NES_BITS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } nes_state_t;

endpackage

// File: rtl/nes_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous input.
// Ports: clock, reset (sync, active-high), raw (async input),
//        level (synchronized), rise/fall (single-cycle edge events).
module nes_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], raw};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/nes_controller_emulator.sv
// Device-side NES controller (4021-style): serializes eight buttons,
// active-low, on the reader's latch/serial clock.
// Ports: clock, reset (sync, active-high), latchOrange, clockRed (async),
//        buttons[7:0] (active-high), dataYellow (active-low serial out),
//        pollStrobe, bitIndex[3:0], extraClocks, busy (frame status).
module nes_controller_emulator
    import nes_pkg::*;
#(
    parameter int   SYNC_STAGES    = 2,
    parameter int   TIMEOUT_CYCLES = 4096,
    parameter logic FILL_LEVEL     = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                latchOrange,
    input  logic                clockRed,
    input  logic [NES_BITS-1:0] buttons,
    output logic                dataYellow,
    output logic                pollStrobe,
    output logic [3:0]          bitIndex,
    output logic                extraClocks,
    output logic                busy
);

    localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TMO_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [3:0]     IDX_MAX = 4'(NES_BITS);

    logic latch_level;
    logic latch_rise;
    logic latch_fall;
    logic clk_level;
    logic clk_rise;
    logic clk_fall;
    logic unused_clk;

    nes_state_t          state;
    logic [NES_BITS-1:0] shift_reg;
    logic [CW-1:0]       tmo_cnt;

    nes_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clock (clock),
        .reset (reset),
        .raw   (latchOrange),
        .level (latch_level),
        .rise  (latch_rise),
        .fall  (latch_fall)
    );

    nes_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clock (clock),
        .reset (reset),
        .raw   (clockRed),
        .level (clk_level),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    // Only the serial-clock rising edge matters to the shifter.
    assign unused_clk = clk_level ^ clk_fall;

    // The line is driven straight from the register's LSB.
    assign dataYellow = shift_reg[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '1;
            pollStrobe  <= 1'b0;
            bitIndex    <= '0;
            extraClocks <= 1'b0;
            busy        <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            pollStrobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (latch_level) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bitIndex    <= '0;
                    extraClocks <= 1'b0;
                    tmo_cnt     <= '0;
                    // Parallel mode: track buttons while latched; the
                    // last latched-high value is what gets shifted out.
                    if (latch_level) begin
                        shift_reg <= ~buttons;
                    end else begin
                        state      <= SHIFT;
                        busy       <= 1'b1;
                        pollStrobe <= latch_fall;
                    end
                end
                SHIFT: begin
                    if (latch_rise) begin
                        state       <= LOAD;
                        busy        <= 1'b0;
                        bitIndex    <= '0;
                        extraClocks <= 1'b0;
                    end else if (clk_rise) begin
                        shift_reg <= {FILL_LEVEL, shift_reg[NES_BITS-1:1]};
                        tmo_cnt   <= '0;
                        if (bitIndex == IDX_MAX) begin
                            extraClocks <= 1'b1;
                        end else begin
                            bitIndex <= bitIndex + 4'd1;
                        end
                    end else if (tmo_cnt == TMO_MAX) begin
                        // Reader went silent: drop the frame, idle line.
                        state     <= IDLE;
                        busy      <= 1'b0;
                        shift_reg <= '1;
                        bitIndex  <= '0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_controller_emulator.sv
// Directed bench for nes_controller_emulator: acts as the NES reader,
// checks outputs against a frame-level model plus literal expectations.
module tb_nes_controller_emulator;
    import nes_pkg::*;

    localparam int TMO = 4096;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       latchOrange = 1'b0;
    logic       clockRed = 1'b0;
    logic [7:0] buttons = 8'h01;
    logic       dataYellow;
    logic       pollStrobe;
    logic [3:0] bitIndex;
    logic       extraClocks;
    logic       busy;

    nes_controller_emulator dut (
        .clock       (clock),
        .reset       (reset),
        .latchOrange (latchOrange),
        .clockRed    (clockRed),
        .buttons     (buttons),
        .dataYellow  (dataYellow),
        .pollStrobe  (pollStrobe),
        .bitIndex    (bitIndex),
        .extraClocks (extraClocks),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int strobes = 0;

    // Frame-level model: which buttons were captured, how many serial
    // clocks the reader has issued since, and whether a frame is live.
    logic       chk_en = 1'b0;
    logic       in_frame = 1'b0;
    logic [7:0] fb = 8'h00;
    int         n = 0;

    function automatic logic m_data();
        if (!in_frame) return 1'b1;
        if (n < 8) return ~fb[n];
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_idx();
        if (!in_frame) return 4'd0;
        return (n > 8) ? 4'd8 : 4'(n);
    endfunction

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (pollStrobe) strobes++;
        if (chk_en) begin
            check("data", dataYellow, m_data());
            check("bit_index", bitIndex, m_idx());
            check("busy", busy, in_frame);
            check("extra", extraClocks, in_frame && (n > 8));
            check("strobe_quiet", pollStrobe, 1'b0);
        end
    end

    task automatic wait_cyc(input int c);
        repeat (c) @(posedge clock);
        #1;
    endtask

    task automatic latch_pulse(input logic [7:0] btn);
        int s0;
        chk_en = 1'b0;
        buttons = btn;
        latchOrange = 1'b1;
        wait_cyc(6);
        check("load_busy", busy, 1'b0);
        check("load_idx", bitIndex, 4'd0);
        check("load_extra", extraClocks, 1'b0);
        s0 = strobes;
        latchOrange = 1'b0;
        wait_cyc(6);
        check("strobe_once", 8'(strobes - s0), 8'd1);
        fb = btn;
        n = 0;
        in_frame = 1'b1;
        chk_en = 1'b1;
        wait_cyc(2);
    endtask

    task automatic ser_clk();
        chk_en = 1'b0;
        clockRed = 1'b1;
        wait_cyc(4);
        clockRed = 1'b0;
        wait_cyc(4);
        n++;
        chk_en = 1'b1;
        wait_cyc(2);
    endtask

    task automatic frame(input logic [7:0] btn, input int nclk,
                         output logic [7:0] seq);
        seq = 8'h00;
        latch_pulse(btn);
        for (int i = 0; i < nclk; i++) begin
            if (i < 8) seq[7-i] = dataYellow;
            ser_clk();
        end
    endtask

    logic [7:0] seq;

    initial begin
        // 1: reset state, then A only
        wait_cyc(3);
        check("rst_data", dataYellow, 1'b1);
        check("rst_idx", bitIndex, 4'd0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        chk_en = 1'b1;
        wait_cyc(3);
        frame(8'h01, 8, seq);
        check("t1_seq", seq, 8'b0111_1111);

        // 2: B, Up, Right
        frame(8'h92, 8, seq);
        check("t2_seq", seq, 8'b1011_0110);
        check("t2_fill", dataYellow, 1'b1);
        check("t2_idx", bitIndex, 4'd8);
        check("t2_extra", extraClocks, 1'b0);

        // 3: reader loopback decode, Up + Left, two frames
        frame(8'h50, 8, seq);
        frame(8'h50, 8, seq);
        check("t3_up", !seq[7-BTN_UP], 1'b1);
        check("t3_left", !seq[7-BTN_LEFT], 1'b1);
        check("t3_down", !seq[7-BTN_DOWN], 1'b0);
        check("t3_right", !seq[7-BTN_RIGHT], 1'b0);

        // 4: ten clocks, next latch clears extraClocks
        frame(8'h3C, 10, seq);
        check("t4_extra", extraClocks, 1'b1);
        check("t4_idx", bitIndex, 4'd8);

        // 5: restart after 3 clocks with new buttons; latency on clock
        frame(8'h01, 3, seq);
        latch_pulse(8'h02);
        check("t5_first", dataYellow, 1'b1);
        chk_en = 1'b0;
        clockRed = 1'b1;
        repeat (3) @(negedge clock);
        check("t5_lat_old", dataYellow, 1'b1);
        @(negedge clock);
        check("t5_lat_new", dataYellow, 1'b0);
        @(posedge clock);
        #1;
        clockRed = 1'b0;
        wait_cyc(4);
        n = 1;
        chk_en = 1'b1;
        wait_cyc(2);

        // 6: timeout after 2 clocks
        latch_pulse(8'hA5);
        ser_clk();
        ser_clk();
        chk_en = 1'b0;
        wait_cyc(TMO - 100);
        check("t6_busy_pre", busy, 1'b1);
        wait_cyc(200);
        check("t6_busy", busy, 1'b0);
        check("t6_data", dataYellow, 1'b1);
        check("t6_idx", bitIndex, 4'd0);
        in_frame = 1'b0;
        n = 0;
        chk_en = 1'b1;
        wait_cyc(3);

        // 6b: synchronous reset mid-SHIFT
        latch_pulse(8'hFF);
        ser_clk();
        ser_clk();
        ser_clk();
        chk_en = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("t6r_data", dataYellow, 1'b1);
        check("t6r_idx", bitIndex, 4'd0);
        check("t6r_busy", busy, 1'b0);
        check("t6r_extra", extraClocks, 1'b0);
        check("t6r_strobe", pollStrobe, 1'b0);
        wait_cyc(2);
        reset = 1'b0;
        in_frame = 1'b0;
        n = 0;
        chk_en = 1'b1;
        wait_cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
